branch_predictor_f: RTL and testbench
=====================================

# branch_predictor_f

Fetch-stage dynamic branch predictor for the pipelined RV32I core. Decodes the fetched instruction, predicts direction and full target PC for conditional branches and JAL, and is trained from the execute stage. Direction comes from a direct-mapped, tagged table of 2-bit saturating counters; table misses fall back to a static policy. Sits beside the PC-select mux in F; the mux takes `oPredTargetF` when `oPredTakenF` is high.

## Interface
Parameters:
- `INDEX_BITS`, 6: table has 2^INDEX_BITS entries; index = PC[INDEX_BITS+1:2].
- `TAG_BITS`, 8: tag = PC[INDEX_BITS+TAG_BITS+1:INDEX_BITS+2]; INDEX_BITS+TAG_BITS ≤ 30.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `iPCF`  in  32  PC of fetched instruction.
- `iInstructionF`  in  32  fetched instruction.
- `iUpdateEnE`  in  1  execute-stage resolved conditional branch this cycle.
- `iPCE`  in  32  PC of resolved branch.
- `iTakenE`  in  1  actual branch outcome.
- `iMispredictE`  in  1  execute detected a misprediction (any type).
- `oPredTakenF`  out  1  redirect fetch.
- `oPredTargetF`  out  32  predicted next PC.
- `oMispredCount`  out  32  saturating misprediction counter.

## Operation
- Entry: valid bit, TAG_BITS tag, 2-bit counter (00 strong NT, 01 weak NT, 10 weak T, 11 strong T).
- Decode in F: opcode 0x6F = JAL, 0x63 = B-type; all others not predicted.
- JAL: always taken; target = iPCF + sign-extended J-immediate {inst[31], inst[19:12], inst[20], inst[30:21], 0}. Table not consulted.
- B-type: offset = sign-extended B-immediate {inst[31], inst[7], inst[30:25], inst[11:8], 0}. Lookup hit (valid && tag match): taken iff counter[1]. Miss: static fallback (see Configuration).
- Taken: oPredTargetF = iPCF + offset (32-bit wrap, carry discarded). Not taken or non-branch: oPredTargetF = iPCF + 4 (wraps), oPredTakenF = 0.
- Update (iUpdateEnE, on edge): hit → counter +1 if iTakenE else −1, saturating at 11/00. Miss → allocate/replace: valid=1, tag written, counter = 10 if taken else 01.
- Misprediction counter: +1 per cycle with iMispredictE high; holds at 0xFFFF_FFFF.
- iMispredictE independent of iUpdateEnE; both may be high.

## Timing
- Prediction combinational from iPCF/iInstructionF and current table state; zero latency.
- Update written on the rising edge with iUpdateEnE; visible to lookups the following cycle.
- Same-cycle lookup and update of same index: lookup uses pre-update state; no bypass.
- Reset (any cycle, incl. mid-training): on the edge with rst high, all valid=0, counters=01, tags=0, oMispredCount=0. Updates and counter increments in a reset cycle are discarded. Table fully cleared in one cycle (flop array).
- During/after reset, oPredTakenF/oPredTargetF follow the combinational rules against the cleared table (JAL still taken; B-type uses fallback).

## Configuration
- `BP_BACKWARD_FALLBACK_EN` defined: B-type miss predicts taken iff offset negative (inst[31]=1) — backward-taken/forward-not-taken.
- Not defined: B-type miss predicts not taken (target iPCF+4).
- Table, JAL handling and counter identical either way.

## Test plan
- Reset, BEQ at 0x100 with offset −8: macro on → taken, target 0x0F8; macro off → not taken, target 0x104.
- JAL at 0x200, offset +0x40, empty table → taken, target 0x240; table contents unchanged.
- Train 0x100 (forward offset +0x20): update taken → counter 10, predict taken to 0x120; taken again → 11; three not-taken → 10, 01, 00 (predict not taken, 0x104); a fourth not-taken holds 00.
- Aliasing (INDEX_BITS=6): train 0x100 taken, then update 0x200 not-taken (same index 0, different tag) → entry replaced with counter 01; lookup of 0x100 misses and uses fallback.
- Same-cycle hazard: entry at 0x100 counter 01, lookup 0x100 while updating taken → prediction not taken this cycle, taken (counter 10) next cycle.
- Assert iMispredictE 5 cycles → oMispredCount=5; assert rst mid-sequence with iUpdateEnE high → count 0, all lookups miss; preload count 0xFFFF_FFFE, two more mispredicts → holds 0xFFFF_FFFF.

Source files
------------

// File: rtl/branch_predictor_f.sv
// Fetch-stage branch predictor: tagged 2-bit counter table, JAL always taken.
// Define BP_BACKWARD_FALLBACK_EN for backward-taken fallback on table misses.
module branch_predictor_f #(
    parameter int INDEX_BITS = 6,
    parameter int TAG_BITS   = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] iPCF,
    input  logic [31:0] iInstructionF,
    input  logic        iUpdateEnE,
    input  logic [31:0] iPCE,
    input  logic        iTakenE,
    input  logic        iMispredictE,
    output logic        oPredTakenF,
    output logic [31:0] oPredTargetF,
    output logic [31:0] oMispredCount
);

    localparam int ENTRIES = 1 << INDEX_BITS;

    localparam logic [6:0] OP_JAL = 7'h6F;
    localparam logic [6:0] OP_BR  = 7'h63;

    logic                  valid_q [ENTRIES];
    logic [TAG_BITS-1:0]   tag_q   [ENTRIES];
    logic [1:0]            ctr_q   [ENTRIES];
    logic [31:0]           mispred_q;

    logic [INDEX_BITS-1:0] idx_f;
    logic [TAG_BITS-1:0]   tag_f;
    logic                  hit_f;
    logic [INDEX_BITS-1:0] idx_e;
    logic [TAG_BITS-1:0]   tag_e;
    logic                  hit_e;

    logic                  is_jal;
    logic                  is_br;
    logic [31:0]           b_off;
    logic [31:0]           j_off;
    logic                  fallback_taken;
    logic                  unused_pc;

    assign unused_pc = ^{iPCF, iPCE};

    assign idx_f = iPCF[INDEX_BITS+1:2];
    assign tag_f = iPCF[INDEX_BITS+TAG_BITS+1:INDEX_BITS+2];
    assign hit_f = valid_q[idx_f] && (tag_q[idx_f] == tag_f);

    assign idx_e = iPCE[INDEX_BITS+1:2];
    assign tag_e = iPCE[INDEX_BITS+TAG_BITS+1:INDEX_BITS+2];
    assign hit_e = valid_q[idx_e] && (tag_q[idx_e] == tag_e);

    assign is_jal = (iInstructionF[6:0] == OP_JAL);
    assign is_br  = (iInstructionF[6:0] == OP_BR);

    assign b_off = {{19{iInstructionF[31]}}, iInstructionF[31],
                    iInstructionF[7], iInstructionF[30:25],
                    iInstructionF[11:8], 1'b0};
    assign j_off = {{11{iInstructionF[31]}}, iInstructionF[31],
                    iInstructionF[19:12], iInstructionF[20],
                    iInstructionF[30:21], 1'b0};

`ifdef BP_BACKWARD_FALLBACK_EN
    assign fallback_taken = iInstructionF[31];
`else
    assign fallback_taken = 1'b0;
`endif

    always_comb begin
        oPredTakenF  = 1'b0;
        oPredTargetF = iPCF + 32'd4;
        unique case (1'b1)
            is_jal: begin
                oPredTakenF  = 1'b1;
                oPredTargetF = iPCF + j_off;
            end
            is_br: begin
                oPredTakenF = hit_f ? ctr_q[idx_f][1] : fallback_taken;
                if (oPredTakenF)
                    oPredTargetF = iPCF + b_off;
            end
            default: ;
        endcase
    end

    // Table is a flop array so reset clears every entry in one edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i] <= 1'b0;
                tag_q[i]   <= '0;
                ctr_q[i]   <= 2'b01;
            end
        end else if (iUpdateEnE) begin
            if (hit_e) begin
                if (iTakenE && ctr_q[idx_e] != 2'b11)
                    ctr_q[idx_e] <= ctr_q[idx_e] + 2'b01;
                else if (!iTakenE && ctr_q[idx_e] != 2'b00)
                    ctr_q[idx_e] <= ctr_q[idx_e] - 2'b01;
            end else begin
                valid_q[idx_e] <= 1'b1;
                tag_q[idx_e]   <= tag_e;
                ctr_q[idx_e]   <= iTakenE ? 2'b10 : 2'b01;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            mispred_q <= '0;
        else if (iMispredictE && mispred_q != 32'hFFFF_FFFF)
            mispred_q <= mispred_q + 32'd1;
    end

    assign oMispredCount = mispred_q;

endmodule

// File: tb/tb_branch_predictor_f.sv
// Directed self-checking bench for branch_predictor_f.
// Expectations follow BP_BACKWARD_FALLBACK_EN when it is defined.
module tb_branch_predictor_f;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] iPCF;
    logic [31:0] iInstructionF;
    logic        iUpdateEnE;
    logic [31:0] iPCE;
    logic        iTakenE;
    logic        iMispredictE;
    logic        oPredTakenF;
    logic [31:0] oPredTargetF;
    logic [31:0] oMispredCount;

    int checks   = 0;
    int failures = 0;

`ifdef BP_BACKWARD_FALLBACK_EN
    localparam bit BWD = 1'b1;
`else
    localparam bit BWD = 1'b0;
`endif

    branch_predictor_f dut (
        .clk          (clk),
        .rst          (rst),
        .iPCF         (iPCF),
        .iInstructionF(iInstructionF),
        .iUpdateEnE   (iUpdateEnE),
        .iPCE         (iPCE),
        .iTakenE      (iTakenE),
        .iMispredictE (iMispredictE),
        .oPredTakenF  (oPredTakenF),
        .oPredTargetF (oPredTargetF),
        .oMispredCount(oMispredCount)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] br(input logic [12:0] off);
        return {off[12], off[10:5], 5'd2, 5'd1, 3'b000,
                off[4:1], off[11], 7'h63};
    endfunction

    function automatic logic [31:0] jal(input logic [20:0] off);
        return {off[20], off[10:1], off[11], off[19:12],
                5'd1, 7'h6F};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic look(input string tag, input logic [31:0] pc,
                        input logic [31:0] inst, input logic tk,
                        input logic [31:0] tgt);
        @(negedge clk);
        iPCF = pc;
        iInstructionF = inst;
        #1;
        chk({tag, "_taken"}, {31'd0, oPredTakenF}, {31'd0, tk});
        chk({tag, "_target"}, oPredTargetF, tgt);
    endtask

    task automatic upd(input logic [31:0] pc, input logic tk);
        @(negedge clk);
        iUpdateEnE = 1'b1;
        iPCE = pc;
        iTakenE = tk;
        @(posedge clk);
        #1 iUpdateEnE = 1'b0;
    endtask

    initial begin
        logic [31:0] bwd8;
        logic [31:0] fwd20;
        bwd8  = br(13'h1FF8);
        fwd20 = br(13'h0020);
        rst = 1'b1;
        iPCF = 32'h100;
        iInstructionF = bwd8;
        iUpdateEnE = 1'b0;
        iPCE = 32'h0;
        iTakenE = 1'b0;
        iMispredictE = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_count", oMispredCount, 32'd0);
        chk("rst_bwd_taken", {31'd0, oPredTakenF}, {31'd0, BWD});
        @(negedge clk) rst = 1'b0;

        look("bwd_miss", 32'h100, bwd8, BWD,
             BWD ? 32'h0F8 : 32'h104);
        look("jal_fwd", 32'h200, jal(21'h40), 1'b1, 32'h240);
        look("bwd_after_jal", 32'h100, bwd8, BWD,
             BWD ? 32'h0F8 : 32'h104);
        look("jal_wrap", 32'h10, jal(21'h1FFFE0), 1'b1, 32'hFFFF_FFF0);
        look("nonbr_wrap", 32'hFFFF_FFFC, 32'h0000_0013, 1'b0, 32'h0);
        look("fwd_miss", 32'h100, fwd20, 1'b0, 32'h104);

        upd(32'h100, 1'b1);
        look("tr_10", 32'h100, fwd20, 1'b1, 32'h120);
        upd(32'h100, 1'b1);
        look("tr_11", 32'h100, fwd20, 1'b1, 32'h120);
        upd(32'h100, 1'b0);
        look("tr_11_10", 32'h100, fwd20, 1'b1, 32'h120);
        upd(32'h100, 1'b0);
        look("tr_01", 32'h100, fwd20, 1'b0, 32'h104);
        upd(32'h100, 1'b0);
        look("tr_00", 32'h100, fwd20, 1'b0, 32'h104);
        upd(32'h100, 1'b0);
        upd(32'h100, 1'b1);
        look("tr_sat00_01", 32'h100, fwd20, 1'b0, 32'h104);
        upd(32'h100, 1'b1);
        look("tr_01_10", 32'h100, fwd20, 1'b1, 32'h120);
        upd(32'h100, 1'b0);
        look("tr_back01", 32'h100, fwd20, 1'b0, 32'h104);

        // same-cycle lookup and update of one entry
        @(negedge clk);
        iPCF = 32'h100;
        iInstructionF = fwd20;
        iUpdateEnE = 1'b1;
        iPCE = 32'h100;
        iTakenE = 1'b1;
        #1;
        chk("hz_pre", {31'd0, oPredTakenF}, 32'd0);
        @(posedge clk);
        #1 iUpdateEnE = 1'b0;
        #1;
        chk("hz_post", {31'd0, oPredTakenF}, 32'd1);
        chk("hz_post_tgt", oPredTargetF, 32'h120);

        upd(32'h200, 1'b0);
        look("alias_old", 32'h100, fwd20, 1'b0, 32'h104);
        look("alias_new", 32'h200, fwd20, 1'b0, 32'h204);
        upd(32'h200, 1'b1);
        look("alias_new_t", 32'h200, fwd20, 1'b1, 32'h220);

        @(negedge clk) iMispredictE = 1'b1;
        repeat (5) @(posedge clk);
        #1 iMispredictE = 1'b0;
        chk("mis_5", oMispredCount, 32'd5);

        upd(32'h100, 1'b1);
        look("pre_rst_hit", 32'h100, fwd20, 1'b1, 32'h120);
        @(negedge clk);
        rst = 1'b1;
        iUpdateEnE = 1'b1;
        iPCE = 32'h100;
        iTakenE = 1'b1;
        iMispredictE = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        iUpdateEnE = 1'b0;
        iMispredictE = 1'b0;
        chk("mid_rst_count", oMispredCount, 32'd0);
        look("rst_miss_100", 32'h100, fwd20, 1'b0, 32'h104);
        look("rst_miss_bwd", 32'h100, bwd8, BWD,
             BWD ? 32'h0F8 : 32'h104);

        @(negedge clk);
        force dut.mispred_q = 32'hFFFF_FFFE;
        #1 release dut.mispred_q;
        #1 chk("preload", oMispredCount, 32'hFFFF_FFFE);
        iMispredictE = 1'b1;
        @(posedge clk);
        #1 chk("sat_1", oMispredCount, 32'hFFFF_FFFF);
        @(posedge clk);
        #1 chk("sat_2", oMispredCount, 32'hFFFF_FFFF);
        iMispredictE = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
